// File: rtl/fact_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fact_seq_ctrl
//
// Moore controller that steps the shared 4-entry register file / ALU datapath
// through an iterative factorial. The result n! ends up in R1.
//
// Register usage:
//   R0  down-counter, starts at n
//   R1  accumulator, holds the result
//   R2  constant 1, used to decrement R0
//   R3  unused
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous active-high reset; forces IDLE and zeroes all outputs
//   start      request pulse; only looked at in IDLE
//   n_in       operand n; latched when a legal start is accepted
//   is_zero    datapath flag: ALU result is zero this cycle
//   ovf        datapath flag: multiply overflowed 32 bits this cycle
//   read_add1  register-file read port A address
//   read_add2  register-file read port B address
//   write_add  register-file write address
//   operation  ALU op (000 ADD, 001 SUB, 010 MUL, 011 PASS_A)
//   wd_selec   write-data select (1 = imm_data, 0 = ALU result)
//   write_en   register-file write strobe
//   imm_data   immediate write value
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   error      sticky overflow / illegal-n flag; cleared by the next legal start
// -----------------------------------------------------------------------------
module fact_seq_ctrl #(
  parameter int N_W   = 5,
  parameter int N_MAX = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] n_in,
  input  logic           is_zero,
  input  logic           ovf,
  output logic [1:0]     read_add1,
  output logic [1:0]     read_add2,
  output logic [1:0]     write_add,
  output logic [2:0]     operation,
  output logic           wd_selec,
  output logic           write_en,
  output logic [31:0]    imm_data,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;

  localparam logic [1:0] R_CNT = 2'd0;
  localparam logic [1:0] R_ACC = 2'd1;
  localparam logic [1:0] R_ONE = 2'd2;

  localparam logic [N_W-1:0] N_MAX_W = N_W'(N_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_N,
    S_LOAD_ONE,
    S_INIT_ACC,
    S_CHECK,
    S_MUL,
    S_DEC,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N_W-1:0] n_q, n_d;
  logic           error_q, error_d;

  // ---------------------------------------------------------------------------
  // State, latched operand and sticky error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      error_q <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_in > N_MAX_W) begin
            // Illegal operand: report straight away without touching the
            // register file.
            state_d = S_DONE;
            error_d = 1'b1;
          end else begin
            state_d = S_LOAD_N;
            n_d     = n_in;
            error_d = 1'b0;
          end
        end
      end
      S_LOAD_N:   state_d = S_LOAD_ONE;
      S_LOAD_ONE: state_d = S_INIT_ACC;
      S_INIT_ACC: state_d = S_CHECK;
      S_CHECK:    state_d = is_zero ? S_DONE : S_MUL;
      S_MUL: begin
        // The overflowed product is still written to R1; the run just stops.
        if (ovf) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else begin
          state_d = S_DEC;
        end
      end
      S_DEC:      state_d = S_CHECK;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: a pure function of the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    read_add1 = 2'd0;
    read_add2 = 2'd0;
    write_add = 2'd0;
    operation = OP_ADD;
    wd_selec  = 1'b0;
    write_en  = 1'b0;
    imm_data  = 32'd0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    case (state_q)
      S_LOAD_N: begin
        write_add = R_CNT;
        wd_selec  = 1'b1;
        write_en  = 1'b1;
        imm_data  = 32'(n_q);
      end
      S_LOAD_ONE: begin
        write_add = R_ONE;
        wd_selec  = 1'b1;
        write_en  = 1'b1;
        imm_data  = 32'd1;
      end
      S_INIT_ACC: begin
        write_add = R_ACC;
        wd_selec  = 1'b1;
        write_en  = 1'b1;
        imm_data  = 32'd1;
      end
      S_CHECK: begin
        // Route the counter through the ALU so is_zero reflects R0.
        read_add1 = R_CNT;
        operation = OP_PASS;
      end
      S_MUL: begin
        read_add1 = R_ACC;
        read_add2 = R_CNT;
        write_add = R_ACC;
        operation = OP_MUL;
        write_en  = 1'b1;
      end
      S_DEC: begin
        read_add1 = R_CNT;
        read_add2 = R_ONE;
        write_add = R_CNT;
        operation = OP_SUB;
        write_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign error = error_q;

endmodule

// File: tb/tb_fact_seq_ctrl.sv
module tb_fact_seq_ctrl;

  localparam int N_W = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [N_W-1:0] n_in;
  logic           is_zero;
  logic           ovf;
  logic [1:0]     read_add1, read_add2, write_add;
  logic [2:0]     operation;
  logic           wd_selec, write_en;
  logic [31:0]    imm_data;
  logic           busy, done, error;

  always #5 clk = ~clk;

  fact_seq_ctrl #(.N_W(N_W), .N_MAX(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_in      (n_in),
    .is_zero   (is_zero),
    .ovf       (ovf),
    .read_add1 (read_add1),
    .read_add2 (read_add2),
    .write_add (write_add),
    .operation (operation),
    .wd_selec  (wd_selec),
    .write_en  (write_en),
    .imm_data  (imm_data),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // Behavioural stand-in for the register file / ALU datapath.
  logic [31:0] rf [4];
  logic [31:0] op_a, op_b, alu_res;
  logic [63:0] prod;
  logic        force_ovf;

  always_comb begin
    op_a = rf[read_add1];
    op_b = rf[read_add2];
    prod = {32'd0, op_a} * {32'd0, op_b};
    case (operation)
      3'b000:  alu_res = op_a + op_b;
      3'b001:  alu_res = op_a - op_b;
      3'b010:  alu_res = prod[31:0];
      3'b011:  alu_res = op_a;
      default: alu_res = 32'd0;
    endcase
  end

  assign is_zero = (alu_res == 32'd0);
  assign ovf     = (operation == 3'b010) && ((prod[63:32] != 32'd0) || force_ovf);

  always @(posedge clk) begin
    if (write_en) rf[write_add] <= wd_selec ? imm_data : alu_res;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({read_add1, read_add2, write_add, operation, wd_selec, write_en,
                imm_data, busy, done, error});
  endfunction

  typedef struct {
    int          n;
    bit          frc;
    bit          hold;
    logic [31:0] res;
    bit          err;
    int          cyc;
    int          writes;
    int          mulw;
  } vec_t;

  vec_t sb[$];

  // Issue one start and follow the run to DONE and the IDLE cycle after it.
  // Cycle k is the k-th cycle after the accepting edge; outputs are sampled
  // at the falling edge inside that cycle.
  task automatic run_case(input vec_t v);
    vec_t  e;
    int    cyc;
    int    wr;
    int    mw;
    bit    busy_ok;
    bit    got_done;
    string tag;
    @(negedge clk);
    n_in      = v.n[N_W-1:0];
    start     = 1'b1;
    force_ovf = v.frc;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (!v.hold) start = 1'b0;
    wr = 0; mw = 0; busy_ok = 1'b1; got_done = 1'b0; cyc = 0;
    tag = $sformatf("n=%0d", v.n);
    for (int k = 1; k <= 100 && !got_done; k++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (k == 1) check({tag, " error_cycle1"}, 64'(error), (v.cyc == 1) ? 64'(v.err) : 64'd0);
      if (write_en) wr++;
      if (write_en && operation == 3'b010) mw++;
      if (done) begin
        got_done = 1'b1;
        cyc      = k;
        check({tag, " error_at_done"}, 64'(error), 64'(v.err));
      end
    end
    e = sb.pop_front();
    check({tag, " done_seen"}, 64'(got_done), 64'd1);
    check({tag, " done_cycle"}, 64'(cyc), 64'(e.cyc));
    check({tag, " busy_whole_run"}, 64'(busy_ok), 64'd1);
    check({tag, " write_count"}, 64'(wr), 64'(e.writes));
    check({tag, " mul_write_count"}, 64'(mw), 64'(e.mulw));
    if (e.n <= 12) check({tag, " result_r1"}, 64'(rf[1]), 64'(e.res));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    check({tag, " idle_after_done"}, 64'(busy), 64'd0);
    check({tag, " error_sticky"}, 64'(error), 64'(e.err));
    $display("run n=%0d ovf_forced=%0d done_cycle=%0d r1=%0d error=%0d",
             e.n, e.frc, cyc, rf[1], error);
    force_ovf = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    bit found;
    int cyc2;
    bit done2;

    vecs[0] = '{n:5,  frc:0, hold:0, res:32'd120,       err:0, cyc:20, writes:13, mulw:5};
    vecs[1] = '{n:0,  frc:0, hold:0, res:32'd1,         err:0, cyc:5,  writes:3,  mulw:0};
    vecs[2] = '{n:1,  frc:0, hold:0, res:32'd1,         err:0, cyc:8,  writes:5,  mulw:1};
    vecs[3] = '{n:12, frc:0, hold:0, res:32'd479001600, err:0, cyc:41, writes:27, mulw:12};
    vecs[4] = '{n:13, frc:0, hold:0, res:32'd0,         err:1, cyc:1,  writes:0,  mulw:0};
    vecs[5] = '{n:3,  frc:1, hold:0, res:32'd3,         err:1, cyc:6,  writes:4,  mulw:1};
    vecs[6] = '{n:2,  frc:0, hold:0, res:32'd2,         err:0, cyc:11, writes:7,  mulw:2};

    reset     = 1'b1;
    start     = 1'b0;
    n_in      = '0;
    force_ovf = 1'b0;

    #8;
    check("outputs_in_reset", all_outs(), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("outputs_idle_after_reset", all_outs(), 64'd0);
    $display("reset: outputs=%0h", all_outs());

    for (int i = 0; i < 7; i++) run_case(vecs[i]);

    // start held high through a whole n=4 run, then re-accepted.
    run_case('{n:4, frc:0, hold:1, res:32'd24, err:0, cyc:17, writes:11, mulw:4});
    @(negedge clk);
    check("hold second_run_busy", 64'(busy), 64'd1);
    check("hold second_run_load_n", 64'({write_en, wd_selec, write_add, imm_data}),
          64'({1'b1, 1'b1, 2'd0, 32'd4}));
    start = 1'b0;
    cyc2  = 1;
    done2 = 1'b0;
    for (int k = 2; k <= 100 && !done2; k++) begin
      @(negedge clk);
      if (done) begin
        done2 = 1'b1;
        cyc2  = k;
      end
    end
    check("hold second_run_done_cycle", 64'(cyc2), 64'd17);
    $display("hold: second run done_cycle=%0d r1=%0d", cyc2, rf[1]);
    @(negedge clk);

    // Asynchronous reset in the middle of a MUL cycle.
    @(negedge clk);
    n_in  = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (write_en && operation == 3'b010) found = 1'b1;
    end
    check("async reached_mul", 64'(found), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async write_en_drop", 64'(write_en), 64'd0);
    check("async busy_drop", 64'(busy), 64'd0);
    check("async outputs_zero", all_outs(), 64'd0);
    $display("async reset mid-MUL: outputs=%0h", all_outs());
    @(negedge clk);
    reset = 1'b0;
    run_case('{n:3, frc:0, hold:0, res:32'd6, err:0, cyc:14, writes:9, mulw:3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
